cpu_stoc_buf: RTL and testbench



---
 rtl/cpu_stoc_pkg.sv | 16 +
 rtl/cpu_stoc_fifo.sv | 56 +++++
 rtl/cpu_stoc_buf.sv | 128 ++++++++++++
 tb/tb_cpu_stoc_buf.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_stoc_pkg.sv
// Shared types and helpers for the STOC store-to-CD buffer.
// Drain FSM states and the level-width helper used by the FIFO and top.
package cpu_stoc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } drainState_t;

  // Occupancy needs to represent 0..depth inclusive.
  function automatic int levelWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/cpu_stoc_fifo.sv
// Register-based synchronous FIFO with occupancy count.
// A push into a full FIFO is accepted when a pop happens on the same edge.
module cpu_stoc_fifo
  import cpu_stoc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int LVL_W  = levelWidth(DEPTH)
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              push,
  input  logic [DATA_W-1:0] pushData,
  input  logic              pop,
  output logic [DATA_W-1:0] popData,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty,
  output logic              pushOk
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic              doPush;
  logic              doPop;

  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign pushOk = doPush;

  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      if (doPush && !doPop)      level <= level + 1'b1;
      else if (doPop && !doPush) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  assign popData = mem[rdPtr];
  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);

endmodule

// File: rtl/cpu_stoc_buf.sv
// STOC store buffer: captures IDB on each STOC_n falling edge into a FIFO
// and replays each word onto the CD bus with a registered drive enable.
module cpu_stoc_buf
  import cpu_stoc_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 4,
  parameter int HOLD_CYC = 1,
  parameter int ACK_MODE = 0,
  parameter int TMO_CYC  = 15
) (
  input  logic                           sysclk,
  input  logic                           sys_rst_n,
  input  logic                           stoc_n_i,
  input  logic [DATA_W-1:0]              idb_i,
  input  logic                           cd_ack_i,
  input  logic                           ovf_clr_i,
  output logic [DATA_W-1:0]              cd_o,
  output logic                           cd_oe_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [levelWidth(DEPTH)-1:0]   level_o,
  output logic                           ovf_o,
  output logic                           tmo_o
);

  localparam int LVL_W   = levelWidth(DEPTH);
  localparam int CNT_MAX = (HOLD_CYC > TMO_CYC) ? HOLD_CYC : TMO_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TMO_CYC - 1);

  drainState_t       state, stateNext;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic [DATA_W-1:0] cdReg, cdNext;
  logic              stocPrev;
  logic              pushReq;
  logic              pushOk;
  logic              popReq;
  logic              tmoSet;
  logic              ovfSet;
  logic              fifoEmpty;
  logic [DATA_W-1:0] headData;

  assign pushReq = stocPrev && !stoc_n_i;
  assign ovfSet  = pushReq && !pushOk;

  cpu_stoc_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .LVL_W  (LVL_W)
  ) u_fifo (
    .clk      (sysclk),
    .rstN     (sys_rst_n),
    .push     (pushReq),
    .pushData (idb_i),
    .pop      (popReq),
    .popData  (headData),
    .level    (level_o),
    .full     (full_o),
    .empty    (fifoEmpty),
    .pushOk   (pushOk)
  );

  assign empty_o = fifoEmpty;

  // Handshake: a word is offered while cd_oe_o=1; with ACK_MODE=1 the consumer
  // accepts it by holding cd_ack_i=1 at a rising edge, which ends the drive.
  // With ACK_MODE=0 cd_ack_i is ignored and the word is held HOLD_CYC cycles.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    cdNext    = cdReg;
    popReq    = 1'b0;
    tmoSet    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifoEmpty) begin
          popReq    = 1'b1;
          cdNext    = headData;
          cntNext   = '0;
          stateNext = DRIVE;
        end
      end
      DRIVE: begin
        if (ACK_MODE != 0) begin
          if (cd_ack_i) begin
            stateNext = GAP;
          end else if (cnt == TMO_LAST) begin
            tmoSet    = 1'b1;
            stateNext = GAP;
          end else begin
            cntNext = cnt + 1'b1;
          end
        end else begin
          if (cnt == HOLD_LAST) stateNext = GAP;
          else                  cntNext   = cnt + 1'b1;
        end
      end
      GAP:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      cdReg    <= '0;
      cd_oe_o  <= 1'b0;
      stocPrev <= 1'b1;
      ovf_o    <= 1'b0;
      tmo_o    <= 1'b0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      cdReg    <= cdNext;
      cd_oe_o  <= (stateNext == DRIVE);
      stocPrev <= stoc_n_i;
      ovf_o    <= ovfSet || (ovf_o && !ovf_clr_i);
      tmo_o    <= tmoSet || (tmo_o && !ovf_clr_i);
    end
  end

  // The bus carries zero whenever it is not being driven.
  assign cd_o = cd_oe_o ? cdReg : '0;

endmodule

// File: tb/tb_cpu_stoc_buf.sv
// Bench for cpu_stoc_buf: three configurations share one stimulus stream
// and are compared every cycle against a queue-based behavioural model.
module tb_cpu_stoc_buf;

  localparam int N   = 3;
  localparam int DW  = 16;
  localparam int LW  = 3;
  localparam int DEP = 4;
  localparam int TMO = 15;
  localparam int P_IDLE  = 0;
  localparam int P_DRIVE = 1;
  localparam int P_GAP   = 2;

  logic          sysclk  = 1'b0;
  logic          sysRstN = 1'b0;
  logic          stocN   = 1'b1;
  logic [DW-1:0] idb     = '0;
  logic          ack     = 1'b0;
  logic          clr     = 1'b0;

  logic [DW-1:0] cdO    [N];
  logic          oeO    [N];
  logic          fullO  [N];
  logic          emptyO [N];
  logic          ovfO   [N];
  logic          tmoO   [N];
  logic [LW-1:0] levelO [N];

  int checks   = 0;
  int failures = 0;
  bit checkEn  = 1'b0;

  always #5 sysclk = ~sysclk;

  // dut0: HOLD=1; dut1: HOLD=3; dut2: ack mode with timeout.
  for (genvar g = 0; g < N; g++) begin : gDut
    cpu_stoc_buf #(
      .DATA_W   (DW),
      .DEPTH    (DEP),
      .HOLD_CYC ((g == 1) ? 3 : 1),
      .ACK_MODE ((g == 2) ? 1 : 0),
      .TMO_CYC  (TMO)
    ) dut (
      .sysclk    (sysclk),
      .sys_rst_n (sysRstN),
      .stoc_n_i  (stocN),
      .idb_i     (idb),
      .cd_ack_i  (ack),
      .ovf_clr_i (clr),
      .cd_o      (cdO[g]),
      .cd_oe_o   (oeO[g]),
      .full_o    (fullO[g]),
      .empty_o   (emptyO[g]),
      .level_o   (levelO[g]),
      .ovf_o     (ovfO[g]),
      .tmo_o     (tmoO[g])
    );
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int holdOf(input int d);
    return (d == 1) ? 3 : 1;
  endfunction

  // ---------------- behavioural reference model ----------------
  logic [DW-1:0] mq [N][$];
  int            phase  [N];
  int            driven [N];
  logic [DW-1:0] cur    [N];
  bit            mOvf   [N];
  bit            mTmo   [N];
  bit            mPrev = 1'b1;

  always @(posedge sysclk or negedge sysRstN) begin
    bit fall;
    bit setO;
    bit setT;
    bit endDrive;
    if (!sysRstN) begin
      for (int d = 0; d < N; d++) begin
        mq[d].delete();
        phase[d]  = P_IDLE;
        driven[d] = 0;
        cur[d]    = '0;
        mOvf[d]   = 1'b0;
        mTmo[d]   = 1'b0;
      end
      mPrev = 1'b1;
    end else begin
      fall = mPrev && !stocN;
      for (int d = 0; d < N; d++) begin
        setO = 1'b0;
        setT = 1'b0;
        if (phase[d] == P_IDLE) begin
          if (mq[d].size() > 0) begin
            cur[d]    = mq[d].pop_front();
            phase[d]  = P_DRIVE;
            driven[d] = 1;
          end
        end else if (phase[d] == P_DRIVE) begin
          // driven[] counts cycles on the bus so far, including this one
          if (d == 2) endDrive = ack || (driven[d] == TMO);
          else        endDrive = (driven[d] == holdOf(d));
          if (endDrive) begin
            if (d == 2 && !ack) setT = 1'b1;
            phase[d] = P_GAP;
          end else begin
            driven[d]++;
          end
        end else begin
          phase[d] = P_IDLE;
        end
        if (fall) begin
          if (mq[d].size() < DEP) mq[d].push_back(idb);
          else                    setO = 1'b1;
        end
        mOvf[d] = setO || (mOvf[d] && !clr);
        mTmo[d] = setT || (mTmo[d] && !clr);
      end
      mPrev = stocN;
    end
  end

  // ---------------- scoreboard: every cycle, every DUT ----------------
  always @(negedge sysclk) begin
    if (checkEn) begin
      for (int d = 0; d < N; d++) begin
        checkVal($sformatf("oe%0d", d),    oeO[d],    phase[d] == P_DRIVE);
        checkVal($sformatf("cd%0d", d),    cdO[d],    (phase[d] == P_DRIVE) ? cur[d] : '0);
        checkVal($sformatf("level%0d", d), levelO[d], mq[d].size());
        checkVal($sformatf("full%0d", d),  fullO[d],  mq[d].size() == DEP);
        checkVal($sformatf("empty%0d", d), emptyO[d], mq[d].size() == 0);
        checkVal($sformatf("ovf%0d", d),   ovfO[d],   mOvf[d]);
        checkVal($sformatf("tmo%0d", d),   tmoO[d],   mTmo[d]);
      end
    end
  end

  // Word order and drive run length, observed on the bus.
  logic [DW-1:0] seen [N][$];
  logic          prevOe  [N];
  int            runCur  [N];
  int            lastRun [N];

  always @(negedge sysclk) begin
    for (int d = 0; d < N; d++) begin
      if (oeO[d] === 1'b1 && prevOe[d] !== 1'b1) seen[d].push_back(cdO[d]);
      if (oeO[d] === 1'b1) begin
        runCur[d]++;
      end else begin
        if (runCur[d] > 0) lastRun[d] = runCur[d];
        runCur[d] = 0;
      end
      prevOe[d] = oeO[d];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge sysclk);
  endtask

  task automatic strobe(input logic [DW-1:0] d, input int lowCyc);
    @(negedge sysclk);
    stocN = 1'b0;
    idb   = d;
    repeat (lowCyc) @(negedge sysclk);
    stocN = 1'b1;
    idb   = DW'($urandom);
  endtask

  task automatic pulseClr();
    @(negedge sysclk);
    clr = 1'b1;
    @(negedge sysclk);
    clr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int peak;
    int oeCnt;
    repeat (3) tick();
    sysRstN = 1'b1;
    checkEn = 1'b1;

    // reset state
    checkVal("rst_cd",    cdO[0],    0);
    checkVal("rst_oe",    oeO[0],    0);
    checkVal("rst_level", levelO[0], 0);
    checkVal("rst_empty", emptyO[0], 1);
    checkVal("rst_full",  fullO[0],  0);
    checkVal("rst_ovf",   ovfO[2],   0);
    checkVal("rst_tmo",   tmoO[2],   0);

    // single store, HOLD=1 latency
    strobe(16'h1234, 1);
    tick();
    checkVal("lat_oe", oeO[0], 1);
    checkVal("lat_cd", cdO[0], 16'h1234);
    tick();
    checkVal("lat_oe_off", oeO[0], 0);
    checkVal("lat_cd_off", cdO[0], 0);
    checkVal("lat_level",  levelO[0], 0);
    repeat (30) tick();

    // four stores 3 cycles apart while draining, HOLD=3
    seen[1].delete();
    for (int i = 0; i < 4; i++) begin
      strobe(16'hA001 + DW'(i), 1);
      tick();
    end
    repeat (80) tick();
    checkVal("ord_n", seen[1].size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < seen[1].size()) checkVal($sformatf("ord%0d", i), seen[1][i], 16'hA001 + DW'(i));
    checkVal("hold3_len", lastRun[1], 3);
    checkVal("hold3_ovf", ovfO[1], 0);

    // stalled drain: six stores into four entries
    pulseClr();
    seen[2].delete();
    for (int i = 0; i < 6; i++) strobe(16'hB000 + DW'(i), 1);
    checkVal("stall_full",  fullO[2],  1);
    checkVal("stall_level", levelO[2], 4);
    checkVal("stall_ovf",   ovfO[2],   1);
    ack = 1'b1;
    repeat (20) tick();
    ack = 1'b0;
    checkVal("stall_n", seen[2].size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < seen[2].size()) checkVal($sformatf("stall_ord%0d", i), seen[2][i], 16'hB000 + DW'(i));
    pulseClr();
    checkVal("ovf_clr", ovfO[2], 0);
    repeat (30) tick();

    // ack timeout, then next word is driven
    pulseClr();
    seen[2].delete();
    strobe(16'hC001, 1);
    strobe(16'hC002, 1);
    repeat (20) tick();
    checkVal("tmo_len",  lastRun[2], 15);
    checkVal("tmo_flag", tmoO[2],    1);
    checkVal("tmo_next_oe", oeO[2], 1);
    checkVal("tmo_n", seen[2].size(), 2);
    if (seen[2].size() == 2) checkVal("tmo_next_cd", seen[2][1], 16'hC002);
    repeat (20) tick();

    // ack arriving in the 15th drive cycle beats the timeout
    pulseClr();
    strobe(16'hC003, 1);
    tick();
    checkVal("ack15_start", oeO[2], 1);
    repeat (14) tick();
    checkVal("ack15_still", oeO[2], 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checkVal("ack15_tmo", tmoO[2], 0);
    checkVal("ack15_oe",  oeO[2],  0);
    repeat (20) tick();

    // strobe held low for 10 cycles: one push only
    tick();
    stocN = 1'b0;
    idb   = 16'hD001;
    peak  = 0;
    repeat (10) begin
      tick();
      idb = DW'($urandom);
      for (int d = 0; d < N; d++) if (int'(levelO[d]) > peak) peak = int'(levelO[d]);
    end
    stocN = 1'b1;
    checkVal("held_peak", peak, 1);
    repeat (20) tick();

    // push on the same edge as an IDLE pop while full
    pulseClr();
    for (int i = 0; i < 5; i++) strobe(16'hE000 + DW'(i), 1);
    checkVal("pp_full", fullO[2], 1);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (oeO[2] !== 1'b1) break;
    end
    checkVal("pp_gap", oeO[2], 0);
    tick();
    stocN = 1'b0;
    idb   = 16'hE005;
    tick();
    stocN = 1'b1;
    checkVal("pp_level", levelO[2], 4);
    checkVal("pp_oe",    oeO[2],    1);
    checkVal("pp_cd",    cdO[2],    16'hE001);
    checkVal("pp_ovf",   ovfO[2],   0);
    ack = 1'b1;
    repeat (20) tick();
    ack = 1'b0;
    repeat (30) tick();

    // asynchronous reset mid-drive with words queued
    for (int i = 0; i < 4; i++) strobe(16'hF001 + DW'(i), 1);
    checkVal("arst_pre_oe", oeO[2], 1);
    @(posedge sysclk);
    #2 sysRstN = 1'b0;
    #1;
    checkVal("arst_oe",    oeO[2],    0);
    checkVal("arst_cd",    cdO[2],    0);
    checkVal("arst_empty", emptyO[2], 1);
    repeat (2) tick();
    sysRstN = 1'b1;
    oeCnt = 0;
    repeat (20) begin
      tick();
      for (int d = 0; d < N; d++) if (oeO[d] === 1'b1) oeCnt++;
    end
    checkVal("arst_quiet", oeCnt, 0);
    checkVal("arst_empty_after", emptyO[2], 1);

    // randomized traffic
    repeat (400) begin
      tick();
      stocN = ($urandom_range(0, 3) != 0);
      idb   = DW'($urandom);
      ack   = ($urandom_range(0, 4) == 0);
      clr   = ($urandom_range(0, 20) == 0);
    end
    tick();
    stocN = 1'b1;
    clr   = 1'b0;
    ack   = 1'b1;
    repeat (60) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
